systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 18 +
 rtl/systolic_feeder.sv | 127 ++++++++++++
 tb/tb_systolic_feeder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array operand feeder.
//   state_t         - feeder FSM state encoding
//   DEF_N/W/DRAIN   - default array dimension, operand width, drain length
package systolic_pkg;

  localparam int DEF_N     = 2;
  localparam int DEF_W     = 32;
  localparam int DEF_DRAIN = DEF_N;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/systolic_feeder.sv
// Feeds an N x N output-stationary systolic array with one matrix product job.
// A job's two matrices are captured on the in_valid/in_ready handshake, the
// array accumulators are cleared, then the operands are streamed in skewed
// order (row i of A delayed by i beats, column j of B delayed by j beats),
// followed by DRAIN zero beats so the last partial products settle.
//
// Ports
//   clock         single clock, posedge
//   reset         synchronous, active-low
//   in_valid      A_mat/B_mat hold a job
//   in_ready      feeder is idle and will take a job this cycle
//   A_mat, B_mat  [row][col] operand matrices
//   A, B          registered skewed lanes to the array (lane i = row/col i)
//   array_clear   one-cycle pulse ahead of the operand stream
//   result_valid  one-cycle pulse when the array holds A_mat x B_mat
//   busy          any state other than IDLE
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for a job, in_ready high
// CLEAR    | one cycle, pulses array_clear
// FEED     | 2N-1 beats of skewed operands, t = 0..2N-2
// DRAIN    | DRAIN beats of zeros while the array finishes
// DONE     | one cycle, pulses result_valid
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int DRAIN = N
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0][N-1:0][W-1:0]  A_mat,
  input  logic [N-1:0][N-1:0][W-1:0]  B_mat,
  output logic [N-1:0][W-1:0]         A,
  output logic [N-1:0][W-1:0]         B,
  output logic                        array_clear,
  output logic                        result_valid,
  output logic                        busy
);

  localparam int TW       = $clog2(2*N + DRAIN) + 1;
  localparam int DRAIN_LT = (DRAIN > 0) ? DRAIN - 1 : 0;
  localparam logic [TW-1:0] FEED_LAST  = TW'(2*N - 2);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_LT);

  state_t                      state, state_nxt;
  logic [TW-1:0]               t, t_nxt;
  logic                        cap_en;
  logic [N-1:0][N-1:0][W-1:0]  a_cap, b_cap;
  logic [N-1:0][W-1:0]         a_nxt, b_nxt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      t     <= '0;
      a_cap <= '0;
      b_cap <= '0;
      A     <= '0;
      B     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      if (cap_en) begin
        a_cap <= A_mat;
        b_cap <= B_mat;
      end
      A <= a_nxt;
      B <= b_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = '0;
    cap_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          cap_en    = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: state_nxt = ST_FEED;
      ST_FEED: begin
        if (t == FEED_LAST) begin
          state_nxt = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (t == DRAIN_LAST) state_nxt = ST_DONE;
        else                 t_nxt     = t + 1'b1;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The lanes are registered, so they are computed for the beat the FSM is
  // about to enter: beat t carries A[i][k] on lane i and B[k][j] on lane j
  // exactly when t equals lane index plus k.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    if (state_nxt == ST_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_nxt) == i + k) begin
            a_nxt[i] = a_cap[i][k];
            b_nxt[i] = b_cap[k][i];
          end
        end
      end
    end
  end

  assign in_ready     = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign array_clear  = (state == ST_CLEAR);
  assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int N     = 2;
  localparam int W     = 32;
  localparam int DRAIN = 2;
  localparam int LAT   = 2*N + DRAIN + 1;
  localparam int NB    = 2*N - 1;

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  logic                        clock;
  logic                        reset;
  logic                        in_valid;
  logic                        in_ready;
  mat_t                        A_mat, B_mat;
  logic [N-1:0][W-1:0]         A, B;
  logic                        array_clear;
  logic                        result_valid;
  logic                        busy;

  int total = 0;
  int bad   = 0;

  systolic_feeder #(.N(N), .W(W), .DRAIN(DRAIN)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A_mat        (A_mat),
    .B_mat        (B_mat),
    .A            (A),
    .B            (B),
    .array_clear  (array_clear),
    .result_valid (result_valid),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected lane value at feed beat t (t outside 0..2N-2 means not feeding).
  function automatic logic [W-1:0] exp_a(mat_t m, int t, int i);
    if (t >= 0 && t < NB && t >= i && t < i + N) return m[i][t-i];
    return '0;
  endfunction

  function automatic logic [W-1:0] exp_b(mat_t m, int t, int j);
    if (t >= 0 && t < NB && t >= j && t < j + N) return m[t-j][j];
    return '0;
  endfunction

  function automatic logic [95:0] prod(mat_t a, mat_t b, int i, int j);
    logic [95:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s += 96'(a[i][k]) * 96'(b[k][j]);
    return s;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = $urandom;
    return m;
  endfunction

  task automatic run_job(input mat_t a, input mat_t b, input bit corrupt, input string name);
    logic [W-1:0] oa [NB][N];
    logic [W-1:0] ob [NB][N];
    logic [95:0]  acc;
    int           waited;
    int           t;
    @(negedge clock);
    in_valid = 1'b1;
    A_mat    = a;
    B_mat    = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    total++;
    if (waited >= 50) begin
      bad++;
      $display("FAIL %s accept_timeout in_ready=%b required 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
      @(negedge clock);
      if (cyc == 1) in_valid = 1'b0;
      if (cyc == 3 && corrupt) begin
        A_mat = '1;
        B_mat = '1;
      end
      if (cyc <= LAT) begin
        total += 4;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy cyc=%0d got=%b required 1", name, cyc, busy); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL %s in_ready cyc=%0d got=%b required 0", name, cyc, in_ready); end
        if (array_clear !== (cyc == 1)) begin bad++; $display("FAIL %s array_clear cyc=%0d got=%b required %b", name, cyc, array_clear, cyc == 1); end
        if (result_valid !== (cyc == LAT)) begin bad++; $display("FAIL %s result_valid cyc=%0d got=%b required %b", name, cyc, result_valid, cyc == LAT); end
        t = cyc - 2;
        for (int i = 0; i < N; i++) begin
          total += 2;
          if (A[i] !== exp_a(a, t, i)) begin bad++; $display("FAIL %s A_lane%0d cyc=%0d got=%h required %h", name, i, cyc, A[i], exp_a(a, t, i)); end
          if (B[i] !== exp_b(b, t, i)) begin bad++; $display("FAIL %s B_lane%0d cyc=%0d got=%h required %h", name, i, cyc, B[i], exp_b(b, t, i)); end
          if (t >= 0 && t < NB) begin
            oa[t][i] = A[i];
            ob[t][i] = B[i];
          end
        end
      end else begin
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready_after got=%b required 1", name, in_ready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_after got=%b required 0", name, busy); end
      end
    end
    // Replay the observed lanes through an ideal output-stationary array:
    // PE(i,j) sees lane A[i] delayed by j and lane B[j] delayed by i.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int s = 0; s < 3*N; s++) begin
          if (s - j >= 0 && s - j < NB && s - i >= 0 && s - i < NB)
            acc += 96'(oa[s-j][i]) * 96'(ob[s-i][j]);
        end
        total++;
        if (acc !== prod(a, b, i, j)) begin
          bad++;
          $display("FAIL %s out[%0d][%0d] got=%h required %h", name, i, j, acc, prod(a, b, i, j));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    A_mat    = '0;
    B_mat    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total += 6;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b required 1", in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b required 0", busy); end
    if (array_clear !== 1'b0) begin bad++; $display("FAIL reset array_clear got=%b required 0", array_clear); end
    if (result_valid !== 1'b0) begin bad++; $display("FAIL reset result_valid got=%b required 0", result_valid); end
    if (A !== '0) begin bad++; $display("FAIL reset A got=%h required 0", A); end
    if (B !== '0) begin bad++; $display("FAIL reset B got=%h required 0", B); end
    reset = 1'b1;
  endtask

  task automatic test_example();
    mat_t a, b;
    a[0][0] = 6;  a[0][1] = 3; a[1][0] = 5; a[1][1] = 4;
    b[0][0] = 10; b[0][1] = 8; b[1][0] = 2; b[1][1] = 1;
    run_job(a, b, 1'b0, "example");
  endtask

  task automatic test_identity();
    mat_t a, b;
    a[0][0] = 1; a[0][1] = 0; a[1][0] = 0; a[1][1] = 1;
    b[0][0] = 1; b[0][1] = 2; b[1][0] = 3; b[1][1] = 4;
    run_job(a, b, 1'b0, "identity");
  endtask

  task automatic test_all_ones();
    run_job('1, '1, 1'b0, "all_ones");
  endtask

  task automatic test_capture_stable();
    run_job(rand_mat(), rand_mat(), 1'b1, "capture_stable");
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) run_job(rand_mat(), rand_mat(), 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    int accepts, clears, rvs, first, prev;
    bool_gap_ok: begin end
    accepts = 0; clears = 0; rvs = 0; first = -1; prev = -1;
    @(negedge clock);
    in_valid = 1'b1;
    A_mat    = rand_mat();
    B_mat    = rand_mat();
    for (int cyc = 0; cyc < 3 * (LAT + 1); cyc++) begin
      total++;
      if (in_ready !== ((cyc % (LAT + 1)) == 0)) begin
        bad++;
        $display("FAIL b2b in_ready cyc=%0d got=%b required %b", cyc, in_ready, (cyc % (LAT + 1)) == 0);
      end
      if (in_ready === 1'b1 && in_valid) begin
        if (prev >= 0) begin
          total++;
          if (cyc - prev != LAT + 1) begin bad++; $display("FAIL b2b spacing got=%0d required %0d", cyc - prev, LAT + 1); end
        end
        prev = cyc;
        accepts++;
      end
      if (array_clear === 1'b1) clears++;
      if (result_valid === 1'b1) rvs++;
      if (cyc == 3 * (LAT + 1) - 1) in_valid = 1'b0;
      @(negedge clock);
    end
    total += 3;
    if (accepts != 3) begin bad++; $display("FAIL b2b accepts got=%0d required 3", accepts); end
    if (clears != 3) begin bad++; $display("FAIL b2b array_clear_count got=%0d required 3", clears); end
    if (rvs != 3) begin bad++; $display("FAIL b2b result_valid_count got=%0d required 3", rvs); end
  endtask

  task automatic test_mid_reset();
    int rv_seen;
    @(negedge clock);
    in_valid = 1'b1;
    A_mat    = rand_mat();
    B_mat    = rand_mat();
    // DUT is idle here, so the next posedge accepts; negedge 3 is FEED t=1.
    repeat (3) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
    reset = 1'b0;
    @(negedge clock);
    total += 4;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset in_ready got=%b required 1", in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset busy got=%b required 0", busy); end
    if (A !== '0) begin bad++; $display("FAIL mid_reset A got=%h required 0", A); end
    if (B !== '0) begin bad++; $display("FAIL mid_reset B got=%h required 0", B); end
    reset   = 1'b1;
    rv_seen = 0;
    repeat (2 * LAT) begin
      @(negedge clock);
      if (result_valid === 1'b1) rv_seen++;
    end
    total++;
    if (rv_seen != 0) begin bad++; $display("FAIL mid_reset stray_result_valid got=%0d required 0", rv_seen); end
    run_job(rand_mat(), rand_mat(), 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_example();
    test_identity();
    test_all_ones();
    test_capture_stable();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
